// File: rtl/serial_set_dispatcher_pkg.sv
// Shared codes, FSM state encodings and range limits for the serial set dispatcher.
package serial_set_dispatcher_pkg;

  localparam logic [2:0] AddrClock = 3'b000;
  localparam logic [2:0] AddrAlarm = 3'b010;
  localparam logic [2:0] AddrCal   = 3'b100;

  localparam logic [7:0] TgtClock = 8'h00;
  localparam logic [7:0] TgtAlarm = 8'h02;
  localparam logic [7:0] TgtCal   = 8'h04;

  localparam logic [7:0] Ack = 8'h06;
  localparam logic [7:0] Nak = 8'h15;

  localparam logic [2:0] StIdle = 3'd0;
  localparam logic [2:0] StTgt  = 3'd1;
  localparam logic [2:0] StBig  = 3'd2;
  localparam logic [2:0] StMid  = 3'd3;
  localparam logic [2:0] StLess = 3'd4;
  localparam logic [2:0] StChk  = 3'd5;
  localparam logic [2:0] StResp = 3'd6;

  // Clock and alarm share time-of-day limits.
  localparam logic [6:0] TimeBigMax  = 7'd23;
  localparam logic [6:0] TimeMidMax  = 7'd59;
  localparam logic [6:0] TimeLessMax = 7'd59;

  localparam logic [6:0] CalBigMax  = 7'd99;
  localparam logic [6:0] CalMidMin  = 7'd1;
  localparam logic [6:0] CalMidMax  = 7'd12;
  localparam logic [6:0] CalLessMin = 7'd1;
  localparam logic [6:0] CalLessMax = 7'd31;

endpackage

// File: rtl/set_range_check.sv
// Combinational range validation of a Big/Middle/Less triple for a given target.
module set_range_check
  import serial_set_dispatcher_pkg::*;
(
  input  logic [2:0] target,
  input  logic [6:0] big,
  input  logic [6:0] middle,
  input  logic [6:0] less,
  output logic       ok
);

  always_comb begin
    ok = 1'b0;
    case (target)
      AddrClock, AddrAlarm: begin
        ok = (big <= TimeBigMax) && (middle <= TimeMidMax) && (less <= TimeLessMax);
      end
      AddrCal: begin
        ok = (big <= CalBigMax) &&
             (middle >= CalMidMin) && (middle <= CalMidMax) &&
             (less >= CalLessMin) && (less <= CalLessMax);
      end
      default: ok = 1'b0;
    endcase
  end

endmodule

// File: rtl/serial_set_dispatcher.sv
// Parses 6-byte set frames from a UART byte stream, commits validated values to
// the clock/alarm/calendar target and returns an ACK or NAK byte.
module serial_set_dispatcher
  import serial_set_dispatcher_pkg::*;
#(
  parameter logic [7:0]  HEADER         = 8'hA5,
  parameter int unsigned TIMEOUT_CYCLES = 50_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [2:0] address,
  output logic [6:0] Less_set,
  output logic [6:0] Middle_set,
  output logic [6:0] Big_set,
  output logic       wr_clock,
  output logic       wr_ala,
  output logic       wr_cla,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready
);

  localparam int unsigned TmrW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TmrW-1:0] TmrLast = TmrW'(TIMEOUT_CYCLES - 1);

  logic [2:0]      state_q, state_d;
  logic [TmrW-1:0] tmr_q, tmr_d;
  logic [7:0]      chk_q, chk_d;
  logic [2:0]      tgt_q, tgt_d;
  logic [6:0]      big_q, big_d, mid_q, mid_d, less_q, less_d;
  logic [2:0]      addr_q, addr_d;
  logic [6:0]      big_set_q, big_set_d, mid_set_q, mid_set_d, less_set_q, less_set_d;
  logic            wr_clock_q, wr_clock_d, wr_ala_q, wr_ala_d, wr_cla_q, wr_cla_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic            tx_valid_q, tx_valid_d;
  logic            range_ok, in_frame, nak;

  set_range_check u_range_check (
    .target (tgt_q),
    .big    (big_q),
    .middle (mid_q),
    .less   (less_q),
    .ok     (range_ok)
  );

  assign in_frame = (state_q != StIdle) && (state_q != StResp);

  always_comb begin
    state_d    = state_q;
    tmr_d      = tmr_q;
    chk_d      = chk_q;
    tgt_d      = tgt_q;
    big_d      = big_q;
    mid_d      = mid_q;
    less_d     = less_q;
    addr_d     = addr_q;
    big_set_d  = big_set_q;
    mid_set_d  = mid_set_q;
    less_set_d = less_set_q;
    wr_clock_d = 1'b0;
    wr_ala_d   = 1'b0;
    wr_cla_d   = 1'b0;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    nak        = 1'b0;

    // A stalled frame is abandoned silently: no response, no write.
    if (in_frame) begin
      if (rx_valid) begin
        tmr_d = '0;
      end else if (tmr_q == TmrLast) begin
        state_d = StIdle;
        tmr_d   = '0;
      end else begin
        tmr_d = tmr_q + 1'b1;
      end
    end

    case (state_q)
      StIdle: begin
        if (rx_valid && (rx_data == HEADER)) begin
          state_d = StTgt;
          tmr_d   = '0;
        end
      end
      StTgt: begin
        if (rx_valid) begin
          chk_d   = rx_data;
          state_d = StBig;
          case (rx_data)
            TgtClock: tgt_d = AddrClock;
            TgtAlarm: tgt_d = AddrAlarm;
            TgtCal:   tgt_d = AddrCal;
            default:  nak = 1'b1;
          endcase
        end
      end
      StBig, StMid, StLess: begin
        if (rx_valid) begin
          chk_d = chk_q ^ rx_data;
          if (rx_data[7]) begin
            nak = 1'b1;
          end else begin
            case (state_q)
              StBig: begin
                big_d   = rx_data[6:0];
                state_d = StMid;
              end
              StMid: begin
                mid_d   = rx_data[6:0];
                state_d = StLess;
              end
              default: begin
                less_d  = rx_data[6:0];
                state_d = StChk;
              end
            endcase
          end
        end
      end
      StChk: begin
        if (rx_valid) begin
          if ((rx_data == chk_q) && range_ok) begin
            state_d    = StResp;
            addr_d     = tgt_q;
            big_set_d  = big_q;
            mid_set_d  = mid_q;
            less_set_d = less_q;
            tx_valid_d = 1'b1;
            tx_data_d  = Ack;
            case (tgt_q)
              AddrAlarm: wr_ala_d   = 1'b1;
              AddrCal:   wr_cla_d   = 1'b1;
              default:   wr_clock_d = 1'b1;
            endcase
          end else begin
            nak = 1'b1;
          end
        end
      end
      StResp: begin
        if (tx_ready) begin
          tx_valid_d = 1'b0;
          state_d    = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (nak) begin
      state_d    = StResp;
      tx_valid_d = 1'b1;
      tx_data_d  = Nak;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      tmr_q      <= '0;
      chk_q      <= '0;
      tgt_q      <= AddrClock;
      big_q      <= '0;
      mid_q      <= '0;
      less_q     <= '0;
      addr_q     <= AddrClock;
      big_set_q  <= '0;
      mid_set_q  <= '0;
      less_set_q <= '0;
      wr_clock_q <= 1'b0;
      wr_ala_q   <= 1'b0;
      wr_cla_q   <= 1'b0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      tmr_q      <= tmr_d;
      chk_q      <= chk_d;
      tgt_q      <= tgt_d;
      big_q      <= big_d;
      mid_q      <= mid_d;
      less_q     <= less_d;
      addr_q     <= addr_d;
      big_set_q  <= big_set_d;
      mid_set_q  <= mid_set_d;
      less_set_q <= less_set_d;
      wr_clock_q <= wr_clock_d;
      wr_ala_q   <= wr_ala_d;
      wr_cla_q   <= wr_cla_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
    end
  end

  assign address    = addr_q;
  assign Big_set    = big_set_q;
  assign Middle_set = mid_set_q;
  assign Less_set   = less_set_q;
  assign wr_clock   = wr_clock_q;
  assign wr_ala     = wr_ala_q;
  assign wr_cla     = wr_cla_q;
  assign tx_data    = tx_data_q;
  assign tx_valid   = tx_valid_q;

endmodule

// File: tb/tb_serial_set_dispatcher.sv
// Directed-vector bench for serial_set_dispatcher with hand-computed expectations.
module tb_serial_set_dispatcher;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       tx_ready = 1'b1;
  logic [2:0] address;
  logic [6:0] Less_set, Middle_set, Big_set;
  logic       wr_clock, wr_ala, wr_cla;
  logic [7:0] tx_data;
  logic       tx_valid;

  int checks = 0;
  int errors = 0;
  int n_clock = 0;
  int n_ala = 0;
  int n_cla = 0;
  int n_multi = 0;

  always #5 clk = ~clk;

  serial_set_dispatcher #(
    .HEADER         (8'hA5),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .address    (address),
    .Less_set   (Less_set),
    .Middle_set (Middle_set),
    .Big_set    (Big_set),
    .wr_clock   (wr_clock),
    .wr_ala     (wr_ala),
    .wr_cla     (wr_cla),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready)
  );

  always @(negedge clk) begin
    if (wr_clock) n_clock++;
    if (wr_ala) n_ala++;
    if (wr_cla) n_cla++;
    if ($countones({wr_clock, wr_ala, wr_cla}) > 1) n_multi++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    tick();
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] t, input logic [7:0] b, input logic [7:0] m,
                            input logic [7:0] l, input logic [7:0] c);
    send(8'hA5);
    send(t);
    send(b);
    send(m);
    send(l);
    send(c);
  endtask

  task automatic check_sets(input string tag, input logic [2:0] a, input int b, input int m,
                            input int l);
    check_eq({tag, " address"}, 32'(address), 32'(a));
    check_eq({tag, " big"}, 32'(Big_set), b);
    check_eq({tag, " middle"}, 32'(Middle_set), m);
    check_eq({tag, " less"}, 32'(Less_set), l);
  endtask

  task automatic check_wr(input string tag, input logic c, input logic a, input logic k);
    check_eq({tag, " wr"}, 32'({wr_clock, wr_ala, wr_cla}), 32'({c, a, k}));
  endtask

  // Response must be present now and gone one cycle after the handshake.
  task automatic expect_resp(input string tag, input logic [7:0] code);
    check_eq({tag, " tx_valid"}, 32'(tx_valid), 1);
    check_eq({tag, " tx_data"}, 32'(tx_data), 32'(code));
    tick();
    check_eq({tag, " tx_valid drop"}, 32'(tx_valid), 0);
    check_eq({tag, " wr cleared"}, 32'({wr_clock, wr_ala, wr_cla}), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_sets(tag, 3'b000, 0, 0, 0);
    check_wr(tag, 1'b0, 1'b0, 1'b0);
    check_eq({tag, " tx_valid"}, 32'(tx_valid), 0);
    check_eq({tag, " tx_data"}, 32'(tx_data), 0);
  endtask

  initial begin
    repeat (3) tick();
    check_reset_outputs("reset");
    reset = 1'b0;
    tick();

    // Clock 12:30:45; checksum 00^0C^1E^2D = 3F.
    send_frame(8'h00, 8'h0C, 8'h1E, 8'h2D, 8'h3F);
    check_wr("f1", 1'b1, 1'b0, 1'b0);
    check_sets("f1", 3'b000, 12, 30, 45);
    expect_resp("f1", 8'h06);

    // Calendar month 13 with good checksum 10 -> NAK, values untouched.
    send_frame(8'h04, 8'h18, 8'h0D, 8'h01, 8'h10);
    check_wr("f2", 1'b0, 1'b0, 1'b0);
    check_sets("f2", 3'b000, 12, 30, 45);
    expect_resp("f2", 8'h15);

    // Alarm 7:00:00, bad then correct checksum (02^07 = 05).
    send_frame(8'h02, 8'h07, 8'h00, 8'h00, 8'h00);
    check_wr("f3", 1'b0, 1'b0, 1'b0);
    expect_resp("f3", 8'h15);
    send_frame(8'h02, 8'h07, 8'h00, 8'h00, 8'h05);
    check_wr("f4", 1'b0, 1'b1, 1'b0);
    check_sets("f4", 3'b010, 7, 0, 0);
    expect_resp("f4", 8'h06);

    // Calendar upper bounds: year 24, month 12, day 31; checksum 0F.
    send_frame(8'h04, 8'h18, 8'h0C, 8'h1F, 8'h0F);
    check_wr("f5", 1'b0, 1'b0, 1'b1);
    check_sets("f5", 3'b100, 24, 12, 31);
    expect_resp("f5", 8'h06);

    // Hour 24 on the clock is one past the limit.
    send_frame(8'h00, 8'h18, 8'h00, 8'h00, 8'h18);
    check_wr("f6", 1'b0, 1'b0, 1'b0);
    check_sets("f6", 3'b100, 24, 12, 31);
    expect_resp("f6", 8'h15);

    // Data byte with bit 7 set NAKs at once.
    send(8'hA5);
    send(8'h00);
    send(8'h80);
    expect_resp("bit7", 8'h15);

    // Unknown target NAKs at once.
    send(8'hA5);
    send(8'h01);
    expect_resp("badtgt", 8'h15);

    // Stall after the Big byte for longer than the timeout.
    send(8'hA5);
    send(8'h00);
    send(8'h0C);
    repeat (20) tick();
    check_eq("timeout tx_valid", 32'(tx_valid), 0);
    check_sets("timeout", 3'b100, 24, 12, 31);
    send_frame(8'h00, 8'h17, 8'h3B, 8'h3B, 8'h17);
    check_wr("f7", 1'b1, 1'b0, 1'b0);
    check_sets("f7", 3'b000, 23, 59, 59);
    expect_resp("f7", 8'h06);

    // Backpressure: response held, extra bytes dropped while pending.
    tx_ready = 1'b0;
    send_frame(8'h00, 8'h01, 8'h02, 8'h03, 8'h00);
    check_wr("f8", 1'b1, 1'b0, 1'b0);
    check_sets("f8", 3'b000, 1, 2, 3);
    send(8'hA5);
    send(8'h00);
    for (int i = 0; i < 6; i++) begin
      check_eq("hold tx_valid", 32'(tx_valid), 1);
      check_eq("hold tx_data", 32'(tx_data), 32'h06);
      tick();
    end
    tx_ready = 1'b1;
    tick();
    check_eq("hs tx_valid drop", 32'(tx_valid), 0);
    send_frame(8'h00, 8'h05, 8'h06, 8'h07, 8'h04);
    check_wr("f9", 1'b1, 1'b0, 1'b0);
    check_sets("f9", 3'b000, 5, 6, 7);
    expect_resp("f9", 8'h06);

    // Reset mid-frame after the Big byte.
    send(8'hA5);
    send(8'h00);
    send(8'h0C);
    reset = 1'b1;
    #1;
    check_reset_outputs("midreset");
    repeat (2) tick();
    reset = 1'b0;
    repeat (4) tick();
    send(8'h1E);
    send(8'h2D);
    send(8'h3F);
    repeat (3) tick();
    check_eq("post reset tx_valid", 32'(tx_valid), 0);
    check_sets("post reset", 3'b000, 0, 0, 0);

    check_eq("wr_clock count", n_clock, 4);
    check_eq("wr_ala count", n_ala, 1);
    check_eq("wr_cla count", n_cla, 1);
    check_eq("wr onehot", n_multi, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
